// File: rtl/bp_fe_pred_update_sched.sv
`default_nettype none
// ============================================================================
// Module   : bp_fe_pred_update_sched
// Purpose  : Arbitrates redirect/attaboy training writes onto the single
//            predictor write port and sequences table-clear sweeps.
//            Optional sweep logic is enabled by BP_FE_PRED_FLUSH_EN.
// Revision : 1.0  initial release
// ============================================================================
module bp_fe_pred_update_sched #(
  parameter int bp_params_p = 0,
  parameter int upd_width_p = 64,
  parameter int fifo_els_p  = 4,
  parameter int flush_els_p = 64
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           redirect_v_i,
  input  logic [upd_width_p-1:0]         redirect_upd_i,
  input  logic                           attaboy_v_i,
  input  logic [upd_width_p-1:0]         attaboy_upd_i,
  output logic                           attaboy_yumi_o,
  output logic                           w_v_o,
  output logic [upd_width_p-1:0]         w_upd_o,
  output logic                           w_redirect_o,
  input  logic                           w_yumi_i,
  input  logic                           flush_i,
  output logic                           flush_v_o,
  output logic [$clog2(flush_els_p)-1:0] flush_idx_o,
  output logic                           busy_o,
  output logic                           init_done_o,
  output logic [7:0]                     drop_cnt_o
);

  localparam int ptr_w_lp = $clog2(fifo_els_p);
  localparam int cnt_w_lp = ptr_w_lp + 1;
  localparam logic [cnt_w_lp-1:0] fifo_els_lp = cnt_w_lp'(fifo_els_p);

`ifdef BP_FE_PRED_FLUSH_EN
  localparam int idx_w_lp = $clog2(flush_els_p);
  localparam logic [idx_w_lp-1:0] idx_last_lp = idx_w_lp'(flush_els_p - 1);
  typedef enum logic [1:0] {e_reset = 2'd0, e_flush = 2'd1, e_run = 2'd2} state_e;
`else
  typedef enum logic [1:0] {e_reset = 2'd0, e_run = 2'd2} state_e;
`endif

  state_e                  state_q, state_d;
  logic [upd_width_p-1:0]  mem_q [fifo_els_p];
  logic [upd_width_p-1:0]  mem_d [fifo_els_p];
  logic [ptr_w_lp-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [cnt_w_lp-1:0]     cnt_q, cnt_d;
  logic                    hold_v_q, hold_v_d;
  logic [upd_width_p-1:0]  hold_upd_q, hold_upd_d;
  logic                    init_done_q, init_done_d;
  logic [7:0]              drop_cnt_q, drop_cnt_d;
`ifdef BP_FE_PRED_FLUSH_EN
  logic [idx_w_lp-1:0]     flush_idx_q, flush_idx_d;
`endif

  logic fifo_full, fifo_empty;
  logic sel_hold, sel_in, sel_fifo, enq, deq, flush_req;

  logic [31:0] unused_cfg;
  assign unused_cfg = 32'(bp_params_p);

  assign fifo_full   = (cnt_q == fifo_els_lp);
  assign fifo_empty  = (cnt_q == '0);
  assign init_done_o = init_done_q;
  assign drop_cnt_o  = drop_cnt_q;

`ifdef BP_FE_PRED_FLUSH_EN
  assign flush_idx_o = (state_q == e_flush) ? flush_idx_q : '0;
`else
  logic unused_flush;
  assign unused_flush = flush_i;
  assign flush_idx_o  = '0;
`endif

  always_comb begin
    state_d        = state_q;
    mem_d          = mem_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    cnt_d          = cnt_q;
    hold_v_d       = hold_v_q;
    hold_upd_d     = hold_upd_q;
    init_done_d    = init_done_q;
    drop_cnt_d     = drop_cnt_q;
`ifdef BP_FE_PRED_FLUSH_EN
    flush_idx_d    = flush_idx_q;
`endif
    sel_hold       = 1'b0;
    sel_in         = 1'b0;
    sel_fifo       = 1'b0;
    enq            = 1'b0;
    deq            = 1'b0;
    flush_req      = 1'b0;
    w_v_o          = 1'b0;
    w_upd_o        = '0;
    w_redirect_o   = 1'b0;
    attaboy_yumi_o = 1'b0;
    flush_v_o      = 1'b0;
    busy_o         = 1'b0;

    case (state_q)
      e_reset: begin
`ifdef BP_FE_PRED_FLUSH_EN
        state_d = e_flush;
`else
        state_d     = e_run;
        init_done_d = 1'b1;
`endif
      end

`ifdef BP_FE_PRED_FLUSH_EN
      e_flush: begin
        flush_v_o = 1'b1;
        busy_o    = 1'b1;
        if (flush_i) begin
          flush_idx_d = '0;
        end else if (flush_idx_q == idx_last_lp) begin
          flush_idx_d = '0;
          init_done_d = 1'b1;
          state_d     = e_run;
        end else begin
          flush_idx_d = flush_idx_q + 1'b1;
        end
        // No write port during a sweep: redirects park in the hold register.
        if (redirect_v_i) begin
          if (hold_v_q && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
          hold_v_d   = 1'b1;
          hold_upd_d = redirect_upd_i;
        end
      end
`endif

      e_run: begin
`ifdef BP_FE_PRED_FLUSH_EN
        flush_req = flush_i;
`endif
        sel_hold = hold_v_q;
        sel_in   = !hold_v_q && redirect_v_i;
        sel_fifo = !hold_v_q && !redirect_v_i && !fifo_empty;

        w_v_o        = sel_hold || sel_in || sel_fifo;
        w_redirect_o = sel_hold || sel_in;
        if (sel_hold)      w_upd_o = hold_upd_q;
        else if (sel_in)   w_upd_o = redirect_upd_i;
        else if (sel_fifo) w_upd_o = mem_q[rd_ptr_q];

        // An accepted attaboy must not be discarded by a same-cycle flush.
        enq            = attaboy_v_i && !fifo_full && !flush_req;
        attaboy_yumi_o = enq;
        deq            = sel_fifo && w_yumi_i;

        if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
        if (enq) begin
          mem_d[wr_ptr_q] = attaboy_upd_i;
          wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        cnt_d = cnt_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);

        if (sel_hold && w_yumi_i) hold_v_d = 1'b0;

`ifdef BP_FE_PRED_FLUSH_EN
        if (flush_req) begin
          rd_ptr_d    = '0;
          wr_ptr_d    = '0;
          cnt_d       = '0;
          hold_v_d    = 1'b0;
          flush_idx_d = '0;
          state_d     = e_flush;
        end
`endif

        if (redirect_v_i && !(sel_in && w_yumi_i)) begin
          if (sel_hold && !w_yumi_i && !flush_req && (drop_cnt_q != 8'hFF))
            drop_cnt_d = drop_cnt_q + 8'd1;
          hold_v_d   = 1'b1;
          hold_upd_d = redirect_upd_i;
        end
      end

      default: state_d = e_reset;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= e_reset;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      hold_v_q    <= 1'b0;
      hold_upd_q  <= '0;
      init_done_q <= 1'b0;
      drop_cnt_q  <= '0;
`ifdef BP_FE_PRED_FLUSH_EN
      flush_idx_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      hold_v_q    <= hold_v_d;
      hold_upd_q  <= hold_upd_d;
      init_done_q <= init_done_d;
      drop_cnt_q  <= drop_cnt_d;
`ifdef BP_FE_PRED_FLUSH_EN
      flush_idx_q <= flush_idx_d;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_bp_fe_pred_update_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_fe_pred_update_sched
// Purpose  : Self-checking bench for bp_fe_pred_update_sched against a
//            queue-based reference model (fifo 4, sweep 8 rows).
// Revision : 1.0  initial release
// ============================================================================
module tb_bp_fe_pred_update_sched;

  localparam int FIFO_ELS  = 4;
  localparam int FLUSH_ELS = 8;
`ifdef BP_FE_PRED_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        redirect_v_i = 1'b0;
  logic [63:0] redirect_upd_i = '0;
  logic        attaboy_v_i = 1'b0;
  logic [63:0] attaboy_upd_i = '0;
  logic        attaboy_yumi_o;
  logic        w_v_o;
  logic [63:0] w_upd_o;
  logic        w_redirect_o;
  logic        w_yumi_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        flush_v_o;
  logic [2:0]  flush_idx_o;
  logic        busy_o;
  logic        init_done_o;
  logic [7:0]  drop_cnt_o;

  bp_fe_pred_update_sched #(
    .bp_params_p (0),
    .upd_width_p (64),
    .fifo_els_p  (FIFO_ELS),
    .flush_els_p (FLUSH_ELS)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .redirect_v_i   (redirect_v_i),
    .redirect_upd_i (redirect_upd_i),
    .attaboy_v_i    (attaboy_v_i),
    .attaboy_upd_i  (attaboy_upd_i),
    .attaboy_yumi_o (attaboy_yumi_o),
    .w_v_o          (w_v_o),
    .w_upd_o        (w_upd_o),
    .w_redirect_o   (w_redirect_o),
    .w_yumi_i       (w_yumi_i),
    .flush_i        (flush_i),
    .flush_v_o      (flush_v_o),
    .flush_idx_o    (flush_idx_o),
    .busy_o         (busy_o),
    .init_done_o    (init_done_o),
    .drop_cnt_o     (drop_cnt_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode 0 = reset idle, 1 = sweeping, 2 = running.
  localparam int M_RST = 0, M_SWEEP = 1, M_RUN = 2;
  int          m_mode;
  int          m_idx;
  bit          m_init;
  int          m_drop;
  bit          m_hold_v;
  logic [63:0] m_hold;
  logic [63:0] m_q[$];

  bit obs_yumi, obs_fv;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic do_reset();
    reset_i = 1'b1; redirect_v_i = 1'b0; attaboy_v_i = 1'b0; w_yumi_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_i  = 1'b0;
    m_mode   = M_RST; m_idx = 0; m_init = 1'b0; m_drop = 0; m_hold_v = 1'b0; m_hold = '0;
    m_q.delete();
  endtask

  task automatic tick(input bit rv, input logic [63:0] ru, input bit av,
                      input logic [63:0] au, input bit yreq, input bit fl);
    bit          e_wv, e_red, e_ay, e_fv, old_hold, fl_eff;
    logic [63:0] e_upd;
    e_wv = 1'b0; e_red = 1'b0; e_ay = 1'b0; e_upd = '0;
    fl_eff = FLUSH_EN && fl;
    redirect_v_i = rv; redirect_upd_i = ru; attaboy_v_i = av; attaboy_upd_i = au; flush_i = fl;
    if (m_mode == M_RUN) begin
      if (m_hold_v)             begin e_wv = 1'b1; e_red = 1'b1; e_upd = m_hold; end
      else if (rv)              begin e_wv = 1'b1; e_red = 1'b1; e_upd = ru; end
      else if (m_q.size() != 0) begin e_wv = 1'b1; e_upd = m_q[0]; end
      e_ay = av && (m_q.size() < FIFO_ELS) && !fl_eff;
    end
    e_fv = (m_mode == M_SWEEP);
    w_yumi_i = yreq && e_wv;
    #3;
    check("w_v", w_v_o, e_wv);
    check("w_redirect", w_redirect_o, e_red);
    check("w_upd", w_upd_o, e_upd);
    check("attaboy_yumi", attaboy_yumi_o, e_ay);
    check("flush_v", flush_v_o, e_fv);
    check("busy", busy_o, e_fv);
    check("flush_idx", flush_idx_o, e_fv ? m_idx : 0);
    check("init_done", init_done_o, m_init);
    check("drop_cnt", drop_cnt_o, m_drop);
    obs_yumi = attaboy_yumi_o;
    obs_fv   = flush_v_o;
    @(posedge clk);
    #1;
    if (m_mode == M_RUN) begin
      old_hold = m_hold_v;
      if (old_hold && w_yumi_i) m_hold_v = 1'b0;
      if (!old_hold && !rv && m_q.size() != 0 && w_yumi_i) void'(m_q.pop_front());
      if (e_ay) m_q.push_back(au);
      if (fl_eff) begin
        m_q.delete(); m_hold_v = 1'b0; m_mode = M_SWEEP; m_idx = 0;
      end
      if (rv && !(!old_hold && w_yumi_i)) begin
        if (old_hold && !w_yumi_i && !fl_eff && m_drop < 255) m_drop++;
        m_hold = ru; m_hold_v = 1'b1;
      end
    end else if (m_mode == M_SWEEP) begin
      if (rv) begin
        if (m_hold_v && m_drop < 255) m_drop++;
        m_hold = ru; m_hold_v = 1'b1;
      end
      if (fl) m_idx = 0;
      else if (m_idx == FLUSH_ELS - 1) begin m_mode = M_RUN; m_init = 1'b1; end
      else m_idx++;
    end else begin
      if (FLUSH_EN) begin m_mode = M_SWEEP; m_idx = 0; end
      else begin m_mode = M_RUN; m_init = 1'b1; end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    logic [63:0] r1, r2, r3;
    do_reset();

    // Reset release: sweep (if present), attaboys offered throughout.
    cnt = 0;
    for (int i = 0; i < (FLUSH_EN ? 10 : 3); i++) begin
      tick(1'b0, '0, 1'b1, 64'hA000 + 64'(i), 1'b1, 1'b0);
      cnt += int'(obs_fv);
    end
    check("sweep_len", cnt, FLUSH_EN ? FLUSH_ELS : 0);
    for (int i = 0; i < 6; i++) tick(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);

    // Back-pressure fill: six offers, four acceptances, in-order drain.
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, '0, 1'b1, 64'hB0 + 64'(i), 1'b0, 1'b0);
      cnt += int'(obs_yumi);
    end
    check("fill_yumis", cnt, 4);
    for (int i = 0; i < 5; i++) tick(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);

    // Redirect priority over queued attaboys.
    tick(1'b0, '0, 1'b1, 64'hC0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b1, 64'hC1, 1'b0, 1'b0);
    tick(1'b1, 64'hDEAD_0001, 1'b0, '0, 1'b1, 1'b0);
    tick(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    tick(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);

    // Overwrite: newest of three unconsumed redirects wins.
    r1 = rnd64(); r2 = rnd64(); r3 = rnd64();
    tick(1'b1, r1, 1'b0, '0, 1'b0, 1'b0);
    tick(1'b1, r2, 1'b0, '0, 1'b0, 1'b0);
    tick(1'b1, r3, 1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    check("drop_after_overwrite", drop_cnt_o, 2);
    tick(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);

    // Mid-run flush with three attaboys queued, redirect parked mid-sweep.
    for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b1, 64'hE0 + 64'(i), 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    cnt = 0;
    for (int i = 0; i < FLUSH_ELS; i++) begin
      tick(i == 3, 64'hF00D, 1'b0, '0, 1'b1, 1'b0);
      cnt += int'(obs_fv);
    end
    check("reflush_len", cnt, FLUSH_EN ? FLUSH_ELS : 0);
    for (int i = 0; i < 6; i++) tick(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 9) < 3, rnd64(), $urandom_range(0, 1) == 1, rnd64(),
           $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
    end

    // Reset again and confirm clean restart.
    do_reset();
    tick(1'b1, rnd64(), 1'b1, rnd64(), 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
